mul_bus_master: RTL

- Initiator-side controller for the shared tristate multiplier bus (start, func, oe, ready, data).
- Accepts an operand pair on a valid/ready request port and loads A then B over the bus.
- Pulses start, waits for ready, then reads the 2n-bit product as high half followed by low half.
- Returns the product on a valid/ready response port. It replaces hand-sequenced bus stimulus in the datapath.

---
 rtl/mul_bus_master.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mul_bus_master.sv
// Initiator for the shared tristate multiplier bus: loads A and B, pulses start,
// waits for ready (with timeout), reads the product high then low, returns it.
module mul_bus_master #(
  parameter int n       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [n-1:0]   req_a,
  input  logic [n-1:0]   req_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [2*n-1:0] resp_product,
  output logic           resp_timeout,
  output logic           start,
  output logic [1:0]     func,
  output logic           oe,
  input  logic           ready,
  inout  wire  [n-1:0]   data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_TURN, S_START,
    S_WAIT, S_READ_HI, S_READ_LO, S_RELEASE, S_DONE
  } state_t;

  state_t         r_state;
  logic [n-1:0]   r_b;
  logic [n-1:0]   r_dout;
  logic           r_drive;
  logic [n-1:0]   r_hi;
  logic [n-1:0]   r_lo;
  logic [CW-1:0]  r_cnt;
  logic           r_req_ready;
  logic           r_resp_valid;
  logic [2*n-1:0] r_resp_product;
  logic           r_resp_timeout;
  logic           r_start;
  logic [1:0]     r_func;
  logic           r_oe;

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_product = r_resp_product;
  assign resp_timeout = r_resp_timeout;
  assign start        = r_start;
  assign func         = r_func;
  assign oe           = r_oe;
  assign data         = r_drive ? r_dout : 'z;

  // Every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_b            <= '0;
      r_dout         <= '0;
      r_drive        <= 1'b0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_cnt          <= '0;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_product <= '0;
      r_resp_timeout <= 1'b0;
      r_start        <= 1'b0;
      r_func         <= 2'b11;
      r_oe           <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_b         <= req_b;
            r_dout      <= req_a;
            r_drive     <= 1'b1;
            r_func      <= 2'b00;
            r_req_ready <= 1'b0;
            r_state     <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          r_dout  <= r_b;
          r_func  <= 2'b01;
          r_state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          r_drive <= 1'b0;
          r_func  <= 2'b11;
          r_state <= S_TURN;
        end
        S_TURN: begin
          r_start <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          // r_cnt == 0 marks the blind cycle where a stale ready may still be high.
          if (r_cnt != '0 && ready) begin
            r_func  <= 2'b10;
            r_oe    <= 1'b1;
            r_state <= S_READ_HI;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_resp_valid   <= 1'b1;
            r_resp_timeout <= 1'b1;
            r_resp_product <= '0;
            r_state        <= S_DONE;
          end
        end
        S_READ_HI: begin
          r_hi    <= data;
          r_func  <= 2'b11;
          r_state <= S_READ_LO;
        end
        S_READ_LO: begin
          r_lo    <= data;
          r_oe    <= 1'b0;
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          r_resp_valid   <= 1'b1;
          r_resp_timeout <= 1'b0;
          r_resp_product <= {r_hi, r_lo};
          r_state        <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            r_resp_valid   <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_resp_product <= '0;
            r_req_ready    <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_drive     <= 1'b0;
          r_oe        <= 1'b0;
          r_func      <= 2'b11;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
